// File: rtl/mercury2_dac_spi_pkg.sv
// Shared definitions for the Mercury2 dual 10-bit SPI DAC driver:
// FSM states, command-word layout and a command-word builder.
package mercury2_dac_pkg;

    localparam int WORD_W   = 16;
    localparam int CH       = 15;
    localparam int GA       = 13;
    localparam int SHDN     = 12;
    localparam int DATA_MSB = 11;
    localparam int DATA_LSB = 2;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CS_HOLD,
        GAP,
        LDAC
    } state_t;

    // Bit 14 and bits 1..0 are always zero; SHDN is held active.
    function automatic logic [WORD_W-1:0] build_word(
        input logic                           ch,
        input logic                           ga,
        input logic [DATA_MSB-DATA_LSB:0]     din
    );
        logic [WORD_W-1:0] w;
        w                    = '0;
        w[CH]                = ch;
        w[GA]                = ga;
        w[SHDN]              = 1'b1;
        w[DATA_MSB:DATA_LSB] = din;
        return w;
    endfunction

endpackage

// File: rtl/mercury2_dac_spi_if.sv
// Request and DAC pin bundle between the driver and its wrapper/board.
interface mercury2_dac_spi_if;
    logic       trigger;
    logic       channel;
    logic [9:0] Din;
    logic       Busy;
    logic       dac_csn;
    logic       dac_sdi;
    logic       dac_ldac;
    logic       dac_sck;

    modport master (
        output trigger, channel, Din,
        input  Busy, dac_csn, dac_sdi, dac_ldac, dac_sck
    );

    modport slave (
        input  trigger, channel, Din,
        output Busy, dac_csn, dac_sdi, dac_ldac, dac_sck
    );
endinterface

// File: rtl/mercury2_dac_spi_shifter.sv
// 16-bit parallel-load, MSB-first shift register holding the command word.
module mercury2_dac_shifter
    import mercury2_dac_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] data,
    output logic [WORD_W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= data;
        end else if (shift) begin
            q <= {q[WORD_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mercury2_dac_spi.sv
// Mercury2 DAC driver: captures a sample on trigger, shifts a 16-bit SPI
// mode-0 command word out MSB first, then strobes LDAC low.
module mercury2_dac_spi
    import mercury2_dac_pkg::*;
#(
    parameter int ClockDivide = 4,
    parameter int LdacClocks  = 8,
    parameter bit GainBit     = 1'b1
) (
    input logic              clk_50MHZ,
    input logic              reset,
    mercury2_dac_spi_if.slave bus
);

    localparam int H         = ClockDivide / 2;
    localparam int PHASE_MAX = (H > LdacClocks) ? H : LdacClocks;
    localparam int PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam logic [PHASE_W-1:0] HALF_LAST = PHASE_W'(H - 1);
    localparam logic [PHASE_W-1:0] LDAC_LAST = PHASE_W'(LdacClocks - 1);
    localparam logic [3:0]         BIT_LAST  = 4'd15;

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [3:0]         bit_q, bit_d;
    logic               busy_q, busy_d;
    logic               csn_q, csn_d;
    logic               sck_q, sck_d;
    logic               sdi_q, sdi_d;
    logic               ldac_q, ldac_d;
    logic               load, shift;
    logic [WORD_W-1:0]  word_in;
    logic [WORD_W-1:0]  sr_q;

    assign word_in = build_word(bus.channel, GainBit, bus.Din);

    mercury2_dac_shifter u_shifter (
        .clk   (clk_50MHZ),
        .rst   (reset),
        .load  (load),
        .shift (shift),
        .data  (word_in),
        .q     (sr_q)
    );

    always_ff @(posedge clk_50MHZ or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            csn_q   <= 1'b1;
            sck_q   <= 1'b0;
            sdi_q   <= 1'b0;
            ldac_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            busy_q  <= busy_d;
            csn_q   <= csn_d;
            sck_q   <= sck_d;
            sdi_q   <= sdi_d;
            ldac_q  <= ldac_d;
        end
    end

    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        busy_d  = busy_q;
        csn_d   = csn_q;
        sck_d   = sck_q;
        sdi_d   = sdi_q;
        ldac_d  = ldac_q;
        load    = 1'b0;
        shift   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.trigger) begin
                    load    = 1'b1;
                    busy_d  = 1'b1;
                    csn_d   = 1'b0;
                    sck_d   = 1'b0;
                    sdi_d   = word_in[WORD_W-1];
                    phase_d = '0;
                    bit_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (phase_q == HALF_LAST) begin
                    phase_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        // Falling SCK starts the next bit's low phase.
                        sck_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_d = CS_HOLD;
                        end else begin
                            bit_d = bit_q + 4'd1;
                            shift = 1'b1;
                            sdi_d = sr_q[WORD_W-2];
                        end
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            CS_HOLD: begin
                if (phase_q == HALF_LAST) begin
                    phase_d = '0;
                    csn_d   = 1'b1;
                    sdi_d   = 1'b0;
                    state_d = GAP;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            GAP: begin
                if (phase_q == HALF_LAST) begin
                    phase_d = '0;
                    ldac_d  = 1'b0;
                    state_d = LDAC;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            LDAC: begin
                if (phase_q == LDAC_LAST) begin
                    phase_d = '0;
                    ldac_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.Busy     = busy_q;
    assign bus.dac_csn  = csn_q;
    assign bus.dac_sck  = sck_q;
    assign bus.dac_sdi  = sdi_q;
    assign bus.dac_ldac = ldac_q;

endmodule

// File: tb/tb_mercury2_dac_spi.sv
// Scoreboard bench for mercury2_dac_spi: stimulus pushes hand-computed words,
// a pin-level monitor rebuilds each SPI word and checks framing and timing.
module tb_mercury2_dac_spi;

    logic clk_50MHZ = 1'b0;
    logic reset;

    always #10 clk_50MHZ = ~clk_50MHZ;

    mercury2_dac_spi_if bus ();

    mercury2_dac_spi #(
        .ClockDivide (4),
        .LdacClocks  (8),
        .GainBit     (1'b1)
    ) dut (
        .clk_50MHZ (clk_50MHZ),
        .reset     (reset),
        .bus       (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    logic [15:0] sb_q[$];

    int          cyc = 0;
    int          txn_count = 0;
    int          busy_rises = 0;
    int          ldac_falls = 0;
    int          csn_falls = 0;
    bit          check_gap = 1'b0;
    logic        sck_p = 1'b0, csn_p = 1'b1, busy_p = 1'b0, ldac_p = 1'b1, sdi_p = 1'b0;
    logic [15:0] shift_word = '0;
    int          rises = 0, busy_cnt = 0, idle_cnt = 0, ldac_cnt = 0, csn_rise_cyc = 0;

    always @(negedge clk_50MHZ) begin
        cyc++;
        if (reset) begin
            sck_p = 1'b0; csn_p = 1'b1; busy_p = 1'b0; ldac_p = 1'b1; sdi_p = 1'b0;
            rises = 0; shift_word = '0; busy_cnt = 0; idle_cnt = 0; ldac_cnt = 0;
        end else begin
            if (bus.dac_sck && !bus.dac_csn)
                check("sdi_stable_sck_high", 32'(bus.dac_sdi), 32'(sdi_p));
            if (bus.dac_sck && !sck_p && !bus.dac_csn) begin
                shift_word = {shift_word[14:0], bus.dac_sdi};
                rises++;
            end
            if (!bus.dac_csn && csn_p) csn_falls++;
            if (bus.dac_csn && !csn_p) begin
                csn_rise_cyc = cyc;
                check("sck_rises", 32'(rises), 32'd16);
                check("queue_has_entry", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) check("word", 32'(shift_word), 32'(sb_q.pop_front()));
                rises = 0;
            end
            if (!bus.dac_ldac && ldac_p) begin
                ldac_falls++;
                check("csn_to_ldac", 32'(cyc - csn_rise_cyc), 32'd2);
            end
            if (bus.dac_ldac && !ldac_p) begin
                check("ldac_width", 32'(ldac_cnt), 32'd8);
                ldac_cnt = 0;
            end
            if (!bus.dac_ldac) ldac_cnt++;
            if (!bus.Busy && busy_p) begin
                check("busy_width", 32'(busy_cnt), 32'd76);
                busy_cnt = 0;
                idle_cnt = 0;
                txn_count++;
            end
            if (bus.Busy && !busy_p) begin
                busy_rises++;
                if (check_gap) check("busy_gap", 32'(idle_cnt), 32'd1);
                idle_cnt = 0;
            end
            if (bus.Busy) busy_cnt++;
            else idle_cnt++;
            sck_p = bus.dac_sck; csn_p = bus.dac_csn; busy_p = bus.Busy;
            ldac_p = bus.dac_ldac; sdi_p = bus.dac_sdi;
        end
    end

    task automatic tick();
        @(negedge clk_50MHZ);
        #1;
    endtask

    task automatic start(input logic ch, input logic [9:0] din, input logic [15:0] exp);
        tick();
        bus.channel = ch;
        bus.Din     = din;
        bus.trigger = 1'b1;
        sb_q.push_back(exp);
        tick();
        bus.trigger = 1'b0;
        bus.Din     = ~din;
        bus.channel = ~ch;
    endtask

    task automatic wait_txn(input int target, input int budget);
        int n = 0;
        while (txn_count < target && n < budget) begin
            tick();
            n++;
        end
        check("txn_done_in_budget", 32'(txn_count >= target), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(bus.Busy), 32'd0);
        check({tag, "_csn"},  32'(bus.dac_csn), 32'd1);
        check({tag, "_sck"},  32'(bus.dac_sck), 32'd0);
        check({tag, "_sdi"},  32'(bus.dac_sdi), 32'd0);
        check({tag, "_ldac"}, 32'(bus.dac_ldac), 32'd1);
    endtask

    initial begin
        int base;
        int n;
        int falls_before;

        reset       = 1'b0;
        bus.trigger = 1'b0;
        bus.channel = 1'b0;
        bus.Din     = '0;

        // Asynchronous reset before any clock edge.
        #3 reset = 1'b1;
        #1 check_reset_outputs("por");
        repeat (3) tick();
        reset = 1'b0;

        repeat (100) tick();
        check("idle_csn_activity", 32'(csn_falls), 32'd0);
        check("idle_busy", 32'(bus.Busy), 32'd0);

        start(1'b0, 10'h2A5, 16'h3A94);
        wait_txn(1, 200);

        start(1'b1, 10'h3FF, 16'hBFFC);
        wait_txn(2, 200);

        // Trigger at E0+20 with Din=0 must be ignored.
        start(1'b1, 10'h155, 16'hB554);
        repeat (19) tick();
        bus.Din     = 10'h000;
        bus.channel = 1'b0;
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        wait_txn(3, 200);
        repeat (100) tick();
        check("no_extra_txn", 32'(txn_count), 32'd3);
        check("queue_empty", 32'(sb_q.size()), 32'd0);

        // Trigger held high: three back-to-back words.
        tick();
        bus.Din     = 10'h000;
        bus.channel = 1'b0;
        bus.trigger = 1'b1;
        repeat (3) sb_q.push_back(16'h3000);
        base = busy_rises;
        n    = 0;
        while (busy_rises < base + 3 && n < 400) begin
            tick();
            n++;
            if (busy_rises >= base + 1) check_gap = 1'b1;
        end
        bus.trigger = 1'b0;
        check("held_three_starts", 32'(busy_rises - base), 32'd3);
        wait_txn(6, 200);
        check_gap = 1'b0;

        // Reset at E0+30 aborts without an LDAC pulse.
        falls_before = ldac_falls;
        start(1'b0, 10'h2A5, 16'h3A94);
        repeat (29) tick();
        @(posedge clk_50MHZ);
        #3 reset = 1'b1;
        #1 check_reset_outputs("abort");
        void'(sb_q.pop_front());
        repeat (2) tick();
        reset = 1'b0;
        repeat (20) tick();
        check("ldac_not_pulsed", 32'(ldac_falls), 32'(falls_before));
        check("aborted_not_counted", 32'(txn_count), 32'd6);

        start(1'b1, 10'h1C3, 16'hB70C);
        wait_txn(7, 200);
        check("final_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/mercury2_dac_spi.md
Name: mercury2_dac_spi

Overview:
- Serial driver for the Mercury2 board's dual 10-bit SPI DAC (MCP4812-class part with an LDAC pin).
- On a trigger it captures a 10-bit sample and a channel select, then shifts a 16-bit command word out, MSB first, in SPI mode 0.
- After the word it pulses LDAC low to update the analog output, and holds Busy high for the whole transaction.
- It sits below a wrapper that extends Busy to cover analog settling time.

Parameters:
- ClockDivide, 4: clk_50MHZ cycles per SCK period. Must be even and ≥2. The default gives 12.5 MHz, which is below the DAC's 20 MHz maximum.
- LdacClocks, 8: width of the LDAC low pulse in clocks (160 ns at 50 MHz).
- GainBit, 1: value placed in the GA bit. 1 selects 1x gain.

Ports:
- clk_50MHZ  input  1  system clock, 50 MHz, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- trigger  input  1  start request. Sampled on a rising clock edge while idle.
- channel  input  1  0 = DAC A, 1 = DAC B. Captured with trigger.
- Din  input  10  sample value. Captured with trigger.
- Busy  output  1  high while a transaction is in progress.
- dac_csn  output  1  DAC chip select, active low.
- dac_sdi  output  1  serial data to the DAC.
- dac_ldac  output  1  DAC latch strobe, active low.
- dac_sck  output  1  serial clock. Idles low.

Behaviour:
- All outputs are registered. One clock, clk_50MHZ. Asynchronous active-high reset.
- Reset values: Busy=0, dac_csn=1, dac_sck=0, dac_sdi=0, dac_ldac=1, state IDLE.
- Reset asserted mid-transaction aborts it immediately and returns to the reset values. No partial word is latched, because LDAC is never pulsed.
- Let H = ClockDivide/2.
- Command word, bits 15..0:
  - bit 15: channel
  - bit 14: 0
  - bit 13: GainBit
  - bit 12: 1 (SHDN = active)
  - bits 11..2: Din[9:0]
  - bits 1..0: 00
- States: IDLE → SHIFT → CS_HOLD → GAP → LDAC → IDLE.
- IDLE: on edge E0 with trigger=1:
  - capture the word into a 16-bit shift register;
  - Busy←1, dac_csn←0, dac_sdi←bit 15, dac_sck←0;
  - enter SHIFT.
- SHIFT: bit k (k = 0..15, MSB first) occupies E0+4k … E0+4k+4 at the default divide.
  - sdi changes at the start of the bit's low phase.
  - Low phase lasts H clocks, then sck=1 for H clocks.
  - The DAC samples on the rising SCK edge. sdi is stable for H clocks on each side of that edge.
- CS_HOLD: after the 16th high phase, sck←0. Hold for H clocks, then dac_csn←1 and dac_sdi←0.
- GAP: csn stays high for H clocks.
- LDAC: dac_ldac←0 for LdacClocks clocks, then dac_ldac←1 and Busy←0. Return to IDLE.
- Default total Busy time: 16·4 + 2 + 2 + 8 = 76 clocks.
  - Busy rises at E0 and falls at E0+76.
  - csn is low for E0..E0+66.
  - ldac is low for E0+68..E0+76.
- trigger while Busy=1 is ignored, and the captured data is unaffected.
- trigger held high continuously starts a new transaction on the first edge in IDLE, i.e. the edge after Busy falls. Back-to-back transactions are therefore separated by exactly one idle clock.
- Din and channel may change freely after the capture edge.
- Counters: bit counter 0..15, phase counter 0..max(H, LdacClocks)−1. Size them for the parameters; no wrap-around is visible externally.

Decomposition:
- Shared package mercury2_dac_pkg holds:
  - the state enum (IDLE, SHIFT, CS_HOLD, GAP, LDAC);
  - command bit-position constants (CH=15, GA=13, SHDN=12, DATA_MSB=11, DATA_LSB=2);
  - the command-word width of 16.
- One natural sub-module: mercury2_dac_shifter, a 16-bit parallel-load, MSB-first shift register with load and shift enables.
- Timing and FSM logic live in the top block.

Test Plan:
- Reset then idle: assert reset mid-clock (asynchronously) → Busy=0, csn=1, sck=0, ldac=1 immediately. No activity for 100 clocks with trigger=0.
- Single write, DAC A, Din=10'h2A5, channel=0 → 16 sck rising edges while csn=0. Shifted word = 16'h3A94. Busy high exactly 76 clocks. ldac low 8 clocks starting 2 clocks after csn rises.
- DAC B full-scale, Din=10'h3FF, channel=1 → word 16'hBFFC. sdi is stable at every sck rise and changes only while sck=0.
- Trigger during Busy: pulse trigger at E0+20 with Din=0 → ignored; the first word completes unchanged and no second transaction starts.
- Trigger held high with Din=10'h000, channel=0 → word 16'h3000 repeats. Busy is low exactly one clock between transactions.
- Reset at E0+30 → all outputs return to reset values at once; ldac never pulses; next trigger produces a correct full word.
